chip8_mem_arbiter: RTL and testbench

Single-port arbiter and sequencer for the 4 KB CHIP-8 main memory. It shares the memory between three requesters: the ROM loader, the CPU (opcode fetch, BCD and register-file bursts), and the sprite draw engine (DRW row reads). It enforces a boot phase in which only the loader may access memory. After boot it round-robins the CPU and draw engine, with bounded burst locking and write protection of the interpreter area (0x000–0x1FF, font storage).

---
 rtl/chip8_mem_arbiter_if.sv | 31 +++
 rtl/chip8_mem_arbiter.sv | 83 ++++++++
 tb/tb_chip8_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_arbiter_if.sv
// chip8_mem_arbiter_if: requester, status and memory-side signals of the CHIP-8 memory arbiter
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              ld_req, ld_we, ld_done, ld_gnt;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              drw_req, drw_lock, drw_gnt, drw_rvalid;
  logic [ADDR_W-1:0] drw_addr;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic              boot_done, prot_err, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_done,
    input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    input  drw_req, drw_lock, drw_addr, mem_rdata,
    output ld_gnt, cpu_gnt, cpu_rvalid, drw_gnt, drw_rvalid,
    output rdata, boot_done, prot_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata, ld_done,
    output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    output drw_req, drw_lock, drw_addr, mem_rdata,
    input  ld_gnt, cpu_gnt, cpu_rvalid, drw_gnt, drw_rvalid,
    input  rdata, boot_done, prot_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: boot-gated, round-robin single-port arbiter for CHIP-8 main memory
module chip8_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16,
  parameter int PROT_TOP = 'h200
) (
  input logic clk_in,
  input logic rst_in,
  chip8_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {BOOT, IDLE, OWN_CPU, OWN_DRW} state_e;
  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          boot_done_q, cpu_rv_q, drw_rv_q;
  logic          ld_g, cpu_g, drw_g, prot, en, we, at_max;
  // cnt_q includes the grant that opened the locked run
  assign at_max = cnt_q >= CW'(MAX_LOCK - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ld_g = 1'b0;
    cpu_g = 1'b0;
    drw_g = 1'b0;
    case (state_q)
      BOOT: begin
        ld_g = bus.ld_req;
        state_d = bus.ld_done ? IDLE : BOOT;
      end
      IDLE: begin
        cpu_g = bus.cpu_req && !(bus.drw_req && rr_q);
        drw_g = bus.drw_req && !cpu_g;
        cnt_d = CW'(1);
        state_d = (cpu_g && bus.cpu_lock) ? OWN_CPU : (drw_g && bus.drw_lock) ? OWN_DRW : IDLE;
      end
      OWN_CPU: begin
        cpu_g = bus.cpu_req;
        cnt_d = cnt_q + CW'(cnt_q != CW'(MAX_LOCK));
        state_d = (!bus.cpu_req || !bus.cpu_lock || (at_max && bus.drw_req)) ? IDLE : OWN_CPU;
      end
      default: begin
        drw_g = bus.drw_req;
        cnt_d = cnt_q + CW'(cnt_q != CW'(MAX_LOCK));
        state_d = (!bus.drw_req || !bus.drw_lock || (at_max && bus.cpu_req)) ? IDLE : OWN_DRW;
      end
    endcase
    rr_d = cpu_g ? 1'b1 : drw_g ? 1'b0 : rr_q;
    prot = cpu_g && bus.cpu_we && (bus.cpu_addr < ADDR_W'(PROT_TOP));
    en = !rst_in && (ld_g || drw_g || (cpu_g && !prot));
    we = !rst_in && (ld_g ? bus.ld_we : (cpu_g && bus.cpu_we && !prot));
  end
  assign bus.ld_gnt     = !rst_in && ld_g;
  assign bus.cpu_gnt    = !rst_in && cpu_g;
  assign bus.drw_gnt    = !rst_in && drw_g;
  assign bus.prot_err   = !rst_in && prot;
  assign bus.mem_en     = en;
  assign bus.mem_we     = we;
  assign bus.mem_addr   = !en ? '0 : ld_g ? bus.ld_addr : cpu_g ? bus.cpu_addr : bus.drw_addr;
  assign bus.mem_wdata  = !we ? {DATA_W{1'b0}} : ld_g ? bus.ld_wdata : bus.cpu_wdata;
  assign bus.rdata      = bus.mem_rdata;
  assign bus.boot_done  = boot_done_q;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.drw_rvalid = drw_rv_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= BOOT;
      rr_q <= 1'b0;
      cnt_q <= '0;
      boot_done_q <= 1'b0;
      cpu_rv_q <= 1'b0;
      drw_rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      boot_done_q <= boot_done_q || (state_q == BOOT && bus.ld_done);
      cpu_rv_q <= cpu_g && !bus.cpu_we;
      drw_rv_q <= drw_g;
    end
  end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: directed test-plan checks plus randomized traffic against a behavioural model
module tb_chip8_mem_arbiter;
  localparam int MAX_LOCK = 16;
  localparam int PROT_TOP = 'h200;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  chip8_mem_arbiter_if bus ();
  chip8_mem_arbiter dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [7:0] font(input int a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #2;
  endtask

  // external synchronous memory
  logic [7:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = font(i);
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  // behavioural reference: ownership as integers, run length, last-served requester
  logic [7:0] ref_mem [4096];
  initial begin
    bit m_armed, m_boot, m_bd, m_cpu_rv, m_drw_rv, lk, oth;
    bit e_ld, e_cpu, e_drw, e_en, e_we, e_pe;
    int m_owner, m_run, m_last, who;
    logic [11:0] e_addr;
    logic [7:0] e_wd, m_rd;
    m_armed = 0;
    m_rd = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = font(i);
    forever begin
      @(negedge clk);
      {e_ld, e_cpu, e_drw, e_en, e_we, e_pe} = '0;
      e_addr = 0;
      e_wd = 0;
      who = 0;
      if (!rst && m_boot) begin
        e_ld = bus.ld_req;
        if (bus.ld_req) begin
          e_en = 1;
          e_we = bus.ld_we;
          e_addr = bus.ld_addr;
          e_wd = bus.ld_we ? bus.ld_wdata : 8'h00;
        end
      end else if (!rst) begin
        if (m_owner != 0) who = ((m_owner == 1) ? bus.cpu_req : bus.drw_req) ? m_owner : 0;
        else if (bus.cpu_req && bus.drw_req) who = (m_last == 1) ? 2 : 1;
        else if (bus.cpu_req) who = 1;
        else if (bus.drw_req) who = 2;
        e_cpu = (who == 1);
        e_drw = (who == 2);
        if (who == 1 && bus.cpu_we && bus.cpu_addr < PROT_TOP) e_pe = 1;
        else if (who == 1) begin
          e_en = 1;
          e_we = bus.cpu_we;
          e_addr = bus.cpu_addr;
          e_wd = bus.cpu_we ? bus.cpu_wdata : 8'h00;
        end
        if (who == 2) begin
          e_en = 1;
          e_addr = bus.drw_addr;
        end
      end
      if (m_armed) begin
        lit("model_ctl",
            {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt, bus.cpu_rvalid, bus.drw_rvalid, bus.boot_done, bus.prot_err, bus.mem_en, bus.mem_we},
            {e_ld, e_cpu, e_drw, m_cpu_rv, m_drw_rv, m_bd, e_pe, e_en, e_we});
        lit("model_addr", bus.mem_addr, e_addr);
        lit("model_wdata", bus.mem_wdata, e_wd);
        if (m_cpu_rv || m_drw_rv) lit("model_rdata", bus.rdata, m_rd);
      end
      if (rst) begin
        m_armed = 1;
        m_boot = 1;
        m_bd = 0;
        m_cpu_rv = 0;
        m_drw_rv = 0;
        m_owner = 0;
        m_run = 0;
        m_last = 2;
      end else begin
        m_cpu_rv = e_cpu && e_en && !e_we;
        m_drw_rv = e_drw;
        if (e_en && !e_we) m_rd = ref_mem[e_addr];
        if (e_we) ref_mem[e_addr] = e_wd;
        if (m_boot) begin
          if (bus.ld_done) begin
            m_boot = 0;
            m_bd = 1;
          end
        end else if (who != 0) begin
          lk = (who == 1) ? bus.cpu_lock : bus.drw_lock;
          oth = (who == 1) ? bus.drw_req : bus.cpu_req;
          m_run = (m_owner == 0) ? 1 : m_run + 1;
          m_owner = (lk && !(m_run >= MAX_LOCK && oth)) ? who : 0;
          m_last = who;
        end else m_owner = 0;
      end
    end
  end

  task automatic quiet();
    {bus.ld_req, bus.ld_we, bus.ld_done, bus.cpu_req, bus.cpu_we, bus.cpu_lock, bus.drw_req, bus.drw_lock} = '0;
    bus.ld_addr = 0;
    bus.ld_wdata = 0;
    bus.cpu_addr = 0;
    bus.cpu_wdata = 0;
    bus.drw_addr = 0;
  endtask

  task automatic fresh_boot();
    nx(); rst = 1; quiet();
    nx(); rst = 0; bus.ld_done = 1;
    nx(); bus.ld_done = 0;
  endtask

  initial begin
    quiet();
    rst = 1;
    nx(); nx();
    @(negedge clk);
    lit("rst_gnts", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}, 0);
    lit("rst_boot_done", bus.boot_done, 0);
    nx(); rst = 0;
    @(negedge clk);
    lit("reset_state", {bus.cpu_rvalid, bus.drw_rvalid, bus.prot_err, bus.mem_en, bus.mem_we, bus.boot_done}, 0);
    lit("reset_addr", bus.mem_addr, 0);
    // boot gating
    nx();
    bus.cpu_req = 1; bus.cpu_addr = 'h200;
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 'h200; bus.ld_wdata = 'hAB;
    @(negedge clk);
    lit("boot_ld_gnt", bus.ld_gnt, 1);
    lit("boot_cpu_stall", bus.cpu_gnt, 0);
    nx(); bus.ld_req = 0; bus.ld_we = 0; bus.ld_done = 1;
    @(negedge clk);
    lit("boot_done_cycle_cpu", bus.cpu_gnt, 0);
    nx(); bus.ld_done = 0;
    @(negedge clk);
    lit("first_cpu_gnt", bus.cpu_gnt, 1);
    lit("boot_done_set", bus.boot_done, 1);
    nx(); bus.cpu_req = 0;
    @(negedge clk);
    lit("boot_rd_rvalid", bus.cpu_rvalid, 1);
    lit("boot_rd_data", bus.rdata, 'hAB);
    // round robin from reset
    fresh_boot();
    bus.cpu_req = 1; bus.drw_req = 1; bus.cpu_addr = 'h300; bus.drw_addr = 'h400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lit("rr_cpu", bus.cpu_gnt, (i % 2) == 0);
      lit("rr_drw", bus.drw_gnt, (i % 2) == 1);
      nx();
    end
    // lock and preemption
    bus.cpu_req = 0; bus.drw_lock = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) bus.cpu_req = 1;
      @(negedge clk);
      lit("lock_drw", bus.drw_gnt, i != 16);
      lit("lock_cpu", bus.cpu_gnt, i == 16);
      nx();
    end
    quiet();
    nx();
    // write protection
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 'h050; bus.cpu_wdata = 'h55;
    @(negedge clk);
    lit("prot_gnt", bus.cpu_gnt, 1);
    lit("prot_err", bus.prot_err, 1);
    lit("prot_en_we", {bus.mem_en, bus.mem_we}, 0);
    nx(); bus.cpu_we = 0;
    @(negedge clk);
    lit("prot_err_pulse", bus.prot_err, 0);
    nx(); bus.cpu_req = 0;
    @(negedge clk);
    lit("font_rvalid", bus.cpu_rvalid, 1);
    lit("font_kept", bus.rdata, 'hF5);
    nx(); bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 'h300;
    @(negedge clk);
    lit("wr_we", bus.mem_we, 1);
    lit("wr_no_err", bus.prot_err, 0);
    nx(); bus.cpu_we = 0;
    nx(); bus.cpu_req = 0;
    @(negedge clk);
    lit("wr_readback", bus.rdata, 'h55);
    // reset mid-burst
    nx(); bus.cpu_req = 1; bus.cpu_lock = 1; bus.cpu_addr = 'h300;
    @(negedge clk);
    lit("burst_gnt0", bus.cpu_gnt, 1);
    nx();
    @(negedge clk);
    lit("burst_gnt1", bus.cpu_gnt, 1);
    nx(); rst = 1;
    @(negedge clk);
    lit("rst_cycle_gnt", bus.cpu_gnt, 0);
    nx(); rst = 0;
    @(negedge clk);
    lit("post_rst_rvalid", bus.cpu_rvalid, 0);
    lit("post_rst_gnt", bus.cpu_gnt, 0);
    lit("post_rst_boot", bus.boot_done, 0);
    for (int i = 0; i < 3; i++) begin
      nx();
      @(negedge clk);
      lit("post_rst_stall", bus.cpu_gnt, 0);
    end
    nx(); bus.ld_done = 1;
    @(negedge clk);
    lit("post_rst_done_cycle", bus.cpu_gnt, 0);
    nx(); bus.ld_done = 0;
    @(negedge clk);
    lit("post_rst_regrant", bus.cpu_gnt, 1);
    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      nx();
      rst = ($urandom_range(0, 399) == 0);
      bus.ld_done = ($urandom_range(0, 19) == 0);
      bus.ld_req = $urandom_range(0, 1);
      bus.ld_we = $urandom_range(0, 1);
      bus.ld_addr = 12'($urandom_range(0, 4095));
      bus.ld_wdata = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) bus.cpu_req = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) bus.drw_req = $urandom_range(0, 1);
      bus.cpu_lock = $urandom_range(0, 1);
      bus.drw_lock = ($urandom_range(0, 9) != 0);
      bus.cpu_we = ($urandom_range(0, 9) < 3);
      bus.cpu_addr = 12'($urandom_range(0, 4095));
      bus.cpu_wdata = 8'($urandom_range(0, 255));
      bus.drw_addr = 12'($urandom_range(0, 4095));
    end
    nx(); quiet(); rst = 0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
